// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: working/phase widths, FSM state encoding,
// arctangent table and gain constant, common to the vectoring and NCO blocks.
package cordic_pkg;

  localparam int CORDIC_WW = 20;   // working width (2 guard + 2 fraction bits over IW=16)
  localparam int CORDIC_PW = 24;   // phase width, 2^PW = one full turn

  // Vectoring output is scaled by the product of 1/cos(atan(2^-k)).
  // Software divides o_mag by this (or multiplies by CORDIC_GAIN_INV_Q16/2^16).
  localparam real         CORDIC_GAIN          = 1.646760258;
  localparam logic [31:0] CORDIC_GAIN_INV_Q16  = 32'd39797;  // round(2^16/1.646760258)

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cordic_state_t;

  // round(atan(2^-k) / 2pi * 2^pw), for pw <= 32.
  // Held at 2^32-per-turn resolution and rounded down to the requested width.
  function automatic logic [31:0] atan_entry(input int k, input int pw);
    logic [31:0] t;
    logic [32:0] r;
    case (k)
      0:  t = 32'h2000_0000;  1:  t = 32'h12E4_051E;
      2:  t = 32'h09FB_385B;  3:  t = 32'h0511_11D4;
      4:  t = 32'h028B_0D43;  5:  t = 32'h0145_D7E1;
      6:  t = 32'h00A2_F61E;  7:  t = 32'h0051_7C55;
      8:  t = 32'h0028_BE53;  9:  t = 32'h0014_5F2F;
      10: t = 32'h000A_2F98;  11: t = 32'h0005_17CC;
      12: t = 32'h0002_8BE6;  13: t = 32'h0001_45F3;
      14: t = 32'h0000_A2FA;  15: t = 32'h0000_517D;
      16: t = 32'h0000_28BE;  17: t = 32'h0000_145F;
      18: t = 32'h0000_0A30;  19: t = 32'h0000_0518;
      20: t = 32'd652;        21: t = 32'd326;
      22: t = 32'd163;        23: t = 32'd81;
      24: t = 32'd41;         25: t = 32'd20;
      26: t = 32'd10;         27: t = 32'd5;
      28: t = 32'd3;          29: t = 32'd1;
      30: t = 32'd1;
      default: t = 32'd0;
    endcase
    if (pw >= 32) return t;
    r = {1'b0, t} + (33'd1 << (31 - pw));
    return 32'(r >> (32 - pw));
  endfunction

endpackage

// File: rtl/cordic_topolar.sv
// Iterative vectoring-mode CORDIC: (x, y) -> (magnitude, phase), one
// micro-rotation per clock, one sample in flight under a ready/valid handshake.
module cordic_topolar
  import cordic_pkg::*;
#(
  parameter int IW      = 16,
  parameter int OW      = 16,
  parameter int WW      = CORDIC_WW,
  parameter int PW      = CORDIC_PW,
  parameter int NSTAGES = 20
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic signed [IW-1:0] i_xval,
  input  logic signed [IW-1:0] i_yval,
  output logic                 o_valid,
  output logic [OW-1:0]        o_mag,
  output logic [PW-1:0]        o_phase
);

  localparam int          KW        = (NSTAGES > 1) ? $clog2(NSTAGES + 1) : 1;
  localparam logic [WW:0] MAG_RND   = (WW + 1)'(1) << (WW - OW - 1);
  localparam logic [PW-1:0] HALF_TURN = {1'b1, {(PW-1){1'b0}}};

  cordic_state_t        state;
  logic signed [WW-1:0] xw, yw, x_ld, y_ld, x_sh, y_sh;
  logic [PW-1:0]        ph, ph_ld, ph_step;
  logic [KW-1:0]        k;
  logic [WW:0]          mag_rnd;

  assign o_ready = (state == ST_IDLE);

  // Load: sign-extend with two fraction bits; fold the left half-plane by 180 deg
  always_comb begin
    x_ld  = WW'(i_xval) <<< 2;
    y_ld  = WW'(i_yval) <<< 2;
    ph_ld = '0;
    if (i_xval[IW-1]) begin
      x_ld  = -x_ld;
      y_ld  = -y_ld;
      ph_ld = HALF_TURN;
    end
  end

  // Single shared shifter pair and arctangent lookup for the current iteration
  assign x_sh    = xw >>> k;
  assign y_sh    = yw >>> k;
  assign ph_step = PW'(atan_entry(int'(k), PW));
  assign mag_rnd = {1'b0, xw} + MAG_RND;

  // Handshake FSM, micro-rotation datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      xw      <= '0;
      yw      <= '0;
      ph      <= '0;
      k       <= '0;
      o_valid <= 1'b0;
      o_mag   <= '0;
      o_phase <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            xw    <= x_ld;
            yw    <= y_ld;
            ph    <= ph_ld;
            k     <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Rotate toward the x axis; y sign picks the direction
          if (!yw[WW-1]) begin
            xw <= xw + y_sh;
            yw <= yw - x_sh;
            ph <= ph + ph_step;
          end else begin
            xw <= xw - y_sh;
            yw <= yw + x_sh;
            ph <= ph - ph_step;
          end
          k <= k + 1'b1;
          if (k == KW'(NSTAGES - 1)) state <= ST_DONE;
        end
        ST_DONE: begin
          o_mag   <= OW'(mag_rnd >> (WW - OW));
          o_phase <= ph;
          o_valid <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
